// File: rtl/cdb_multi.sv
// Multi-lane registered common data bus. In-order ROB commits are buffered in a FIFO.
// Up to NCH entries per cycle are decoded and broadcast to the RS, regfile, LSB, predictor and IF.
module cdb_multi #(
  parameter int NCH   = 2,
  parameter int TAG_W = 4,
  parameter int DEPTH = 8,
  parameter int XLEN  = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic [NCH-1:0]       commit_valid,
  input  logic [NCH*XLEN-1:0]  commit_value,
  input  logic [NCH*TAG_W-1:0] commit_rename,
  input  logic [NCH*5-1:0]     commit_dest,
  input  logic [NCH*2-1:0]     commit_kind,
  input  logic [NCH*XLEN-1:0]  commit_next_pc,
  output logic                 commit_ready,
  input  logic                 cdb_flush,
  input  logic                 bcast_stall,
  output logic [NCH-1:0]       rs_update_flag,
  output logic [NCH*TAG_W-1:0] rs_commit_rename,
  output logic [NCH*XLEN-1:0]  rs_value,
  output logic [NCH-1:0]       register_update_flag,
  output logic [NCH*5-1:0]     register_commit_dest,
  output logic [NCH*XLEN-1:0]  register_value,
  output logic [NCH*TAG_W-1:0] rename_sent_to_register,
  output logic [NCH-1:0]       lsb_update_flag,
  output logic [NCH*TAG_W-1:0] lsb_commit_rename,
  output logic [NCH-1:0]       branch_commit,
  output logic [NCH-1:0]       branch_jump,
  output logic [NCH-1:0]       jalr_commit,
  output logic [NCH*XLEN-1:0]  jalr_addr
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [1:0] K_ALU = 2'd0, K_STORE = 2'd1, K_BRANCH = 2'd2, K_JALR = 2'd3;

  logic [XLEN-1:0]  mem_value   [DEPTH];
  logic [XLEN-1:0]  mem_next_pc [DEPTH];
  logic [TAG_W-1:0] mem_rename  [DEPTH];
  logic [4:0]       mem_dest    [DEPTH];
  logic [1:0]       mem_kind    [DEPTH];

  logic [AW-1:0] head, tail;
  logic [CW-1:0] count;

  logic          push_en, pop_en;
  logic [CW-1:0] offs [NCH];
  logic [CW-1:0] n_valid, n_push, n_avail, n_pop;

  logic [NCH-1:0]   vld_p0;
  logic [XLEN-1:0]  value_p0   [NCH];
  logic [XLEN-1:0]  next_pc_p0 [NCH];
  logic [TAG_W-1:0] rename_p0  [NCH];
  logic [4:0]       dest_p0    [NCH];
  logic [1:0]       kind_p0    [NCH];

  assign commit_ready = rdy && !cdb_flush && ((CW'(DEPTH) - count) >= CW'(NCH));
  assign push_en      = commit_ready;
  assign pop_en       = rdy && !cdb_flush && !bcast_stall;

  // Each valid lane's rank among valid lanes gives its compacted tail offset.
  always_comb begin
    n_valid = '0;
    for (int i = 0; i < NCH; i++) begin
      offs[i] = n_valid;
      if (commit_valid[i]) n_valid = n_valid + CW'(1);
    end
  end

  assign n_push  = push_en ? n_valid : '0;
  assign n_avail = count + n_push;
  assign n_pop   = !pop_en ? '0 : ((n_avail > CW'(NCH)) ? CW'(NCH) : n_avail);

  // Stored entries go first; incoming entries fill the remaining lanes (bypass).
  always_comb begin
    for (int j = 0; j < NCH; j++) begin
      vld_p0[j]     = 1'b0;
      value_p0[j]   = '0;
      next_pc_p0[j] = '0;
      rename_p0[j]  = '0;
      dest_p0[j]    = '0;
      kind_p0[j]    = '0;
      if (CW'(j) < n_pop) begin
        vld_p0[j] = 1'b1;
        if (CW'(j) < count) begin
          value_p0[j]   = mem_value[head + AW'(j)];
          next_pc_p0[j] = mem_next_pc[head + AW'(j)];
          rename_p0[j]  = mem_rename[head + AW'(j)];
          dest_p0[j]    = mem_dest[head + AW'(j)];
          kind_p0[j]    = mem_kind[head + AW'(j)];
        end else begin
          for (int i = 0; i < NCH; i++) begin
            if (commit_valid[i] && (offs[i] == (CW'(j) - count))) begin
              value_p0[j]   = commit_value[i*XLEN +: XLEN];
              next_pc_p0[j] = commit_next_pc[i*XLEN +: XLEN];
              rename_p0[j]  = commit_rename[i*TAG_W +: TAG_W];
              dest_p0[j]    = commit_dest[i*5 +: 5];
              kind_p0[j]    = commit_kind[i*2 +: 2];
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push_en) begin
      for (int i = 0; i < NCH; i++) begin
        if (commit_valid[i]) begin
          mem_value[tail + offs[i][AW-1:0]]   <= commit_value[i*XLEN +: XLEN];
          mem_next_pc[tail + offs[i][AW-1:0]] <= commit_next_pc[i*XLEN +: XLEN];
          mem_rename[tail + offs[i][AW-1:0]]  <= commit_rename[i*TAG_W +: TAG_W];
          mem_dest[tail + offs[i][AW-1:0]]    <= commit_dest[i*5 +: 5];
          mem_kind[tail + offs[i][AW-1:0]]    <= commit_kind[i*2 +: 2];
        end
      end
    end
  end

  // ---- stage p0 -> registered broadcast outputs ----
  always_ff @(posedge clk) begin
    if (rst) begin
      head                    <= '0;
      tail                    <= '0;
      count                   <= '0;
      rs_update_flag          <= '0;
      rs_commit_rename        <= '0;
      rs_value                <= '0;
      register_update_flag    <= '0;
      register_commit_dest    <= '0;
      register_value          <= '0;
      rename_sent_to_register <= '0;
      lsb_update_flag         <= '0;
      lsb_commit_rename       <= '0;
      branch_commit           <= '0;
      branch_jump             <= '0;
      jalr_commit             <= '0;
      jalr_addr               <= '0;
    end else if (cdb_flush) begin
      head                 <= '0;
      tail                 <= '0;
      count                <= '0;
      rs_update_flag       <= '0;
      register_update_flag <= '0;
      lsb_update_flag      <= '0;
      branch_commit        <= '0;
      branch_jump          <= '0;
      jalr_commit          <= '0;
    end else if (rdy) begin
      head  <= head + n_pop[AW-1:0];
      tail  <= tail + n_push[AW-1:0];
      count <= count + n_push - n_pop;
      for (int j = 0; j < NCH; j++) begin
        rs_update_flag[j]       <= vld_p0[j] && (kind_p0[j] == K_ALU);
        register_update_flag[j] <= vld_p0[j] && ((kind_p0[j] == K_ALU) || (kind_p0[j] == K_JALR))
                                   && (dest_p0[j] != 5'd0);
        lsb_update_flag[j]      <= vld_p0[j] && ((kind_p0[j] == K_ALU) || (kind_p0[j] == K_STORE));
        branch_commit[j]        <= vld_p0[j] && (kind_p0[j] == K_BRANCH);
        branch_jump[j]          <= vld_p0[j] && (kind_p0[j] == K_BRANCH) && value_p0[j][0];
        jalr_commit[j]          <= vld_p0[j] && (kind_p0[j] == K_JALR);
        if (vld_p0[j]) begin
          rs_commit_rename[j*TAG_W +: TAG_W]        <= rename_p0[j];
          rs_value[j*XLEN +: XLEN]                  <= value_p0[j];
          register_commit_dest[j*5 +: 5]            <= dest_p0[j];
          register_value[j*XLEN +: XLEN]            <= (kind_p0[j] == K_JALR) ? next_pc_p0[j] : value_p0[j];
          rename_sent_to_register[j*TAG_W +: TAG_W] <= rename_p0[j];
          lsb_commit_rename[j*TAG_W +: TAG_W]       <= rename_p0[j];
          jalr_addr[j*XLEN +: XLEN]                 <= value_p0[j];
        end
      end
    end
  end
endmodule

// File: tb/tb_cdb_multi.sv
// Bench for cdb_multi: directed test-plan steps then randomized traffic,
// checked against a queue-based reference model of the commit/broadcast rules.
module tb_cdb_multi;
  localparam int NCH = 2, TAG_W = 4, DEPTH = 8, XLEN = 32;

  logic clk = 1'b0;
  logic rst, rdy, cdb_flush, bcast_stall;
  logic [NCH-1:0]       commit_valid;
  logic [NCH*XLEN-1:0]  commit_value, commit_next_pc;
  logic [NCH*TAG_W-1:0] commit_rename;
  logic [NCH*5-1:0]     commit_dest;
  logic [NCH*2-1:0]     commit_kind;
  logic                 commit_ready;
  logic [NCH-1:0]       rs_update_flag, register_update_flag, lsb_update_flag;
  logic [NCH-1:0]       branch_commit, branch_jump, jalr_commit;
  logic [NCH*TAG_W-1:0] rs_commit_rename, rename_sent_to_register, lsb_commit_rename;
  logic [NCH*XLEN-1:0]  rs_value, register_value, jalr_addr;
  logic [NCH*5-1:0]     register_commit_dest;

  cdb_multi #(.NCH(NCH), .TAG_W(TAG_W), .DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .commit_valid(commit_valid), .commit_value(commit_value), .commit_rename(commit_rename),
    .commit_dest(commit_dest), .commit_kind(commit_kind), .commit_next_pc(commit_next_pc),
    .commit_ready(commit_ready), .cdb_flush(cdb_flush), .bcast_stall(bcast_stall),
    .rs_update_flag(rs_update_flag), .rs_commit_rename(rs_commit_rename), .rs_value(rs_value),
    .register_update_flag(register_update_flag), .register_commit_dest(register_commit_dest),
    .register_value(register_value), .rename_sent_to_register(rename_sent_to_register),
    .lsb_update_flag(lsb_update_flag), .lsb_commit_rename(lsb_commit_rename),
    .branch_commit(branch_commit), .branch_jump(branch_jump),
    .jalr_commit(jalr_commit), .jalr_addr(jalr_addr)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [XLEN-1:0]  value;
    logic [XLEN-1:0]  next_pc;
    logic [TAG_W-1:0] rename;
    logic [4:0]       dest;
    logic [1:0]       kind;
  } ent_t;

  ent_t q[$];
  int   n_chk = 0, n_fail = 0;
  logic was_rst;
  logic [NCH-1:0]   e_rs, e_reg, e_lsb, e_br, e_bj, e_jalr;
  logic [TAG_W-1:0] e_rs_tag [NCH], e_reg_tag [NCH], e_lsb_tag [NCH];
  logic [XLEN-1:0]  e_rs_val [NCH], e_reg_val [NCH], e_jaddr [NCH];
  logic [4:0]       e_reg_dest [NCH];

  task automatic chk(input string tag, input int lane, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s lane %0d: observed %0h expected %0h", tag, lane, obs, exp);
    end
  endtask

  task automatic set_lane(input int l, input logic [1:0] k, input logic [4:0] d,
                          input logic [TAG_W-1:0] t, input logic [XLEN-1:0] v, input logic [XLEN-1:0] np);
    commit_kind[l*2 +: 2]             = k;
    commit_dest[l*5 +: 5]             = d;
    commit_rename[l*TAG_W +: TAG_W]   = t;
    commit_value[l*XLEN +: XLEN]      = v;
    commit_next_pc[l*XLEN +: XLEN]    = np;
  endtask

  task automatic rand_lane(input int l);
    logic [4:0] d;
    d = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
    set_lane(l, 2'($urandom), d, TAG_W'($urandom), $urandom, $urandom);
  endtask

  task automatic idle();
    rst = 1'b0; rdy = 1'b1; cdb_flush = 1'b0; bcast_stall = 1'b0; commit_valid = '0;
  endtask

  // A retired instruction's effect on each sink, straight from its kind.
  task automatic decode(input int j, input ent_t e);
    e_rs[j]   = (e.kind == 2'd0);
    e_reg[j]  = ((e.kind == 2'd0) || (e.kind == 2'd3)) && (e.dest != 5'd0);
    e_lsb[j]  = (e.kind == 2'd0) || (e.kind == 2'd1);
    e_br[j]   = (e.kind == 2'd2);
    e_bj[j]   = (e.kind == 2'd2) && e.value[0];
    e_jalr[j] = (e.kind == 2'd3);
    e_rs_tag[j]   = e.rename;
    e_rs_val[j]   = e.value;
    e_reg_tag[j]  = e.rename;
    e_reg_dest[j] = e.dest;
    e_reg_val[j]  = (e.kind == 2'd3) ? e.next_pc : e.value;
    e_lsb_tag[j]  = e.rename;
    e_jaddr[j]    = e.value;
  endtask

  task automatic model_step();
    ent_t e;
    was_rst = rst;
    if (rst) begin
      q.delete();
      {e_rs, e_reg, e_lsb, e_br, e_bj, e_jalr} = '0;
      for (int j = 0; j < NCH; j++) begin
        e_rs_tag[j] = '0; e_rs_val[j] = '0; e_reg_tag[j] = '0; e_reg_dest[j] = '0;
        e_reg_val[j] = '0; e_lsb_tag[j] = '0; e_jaddr[j] = '0;
      end
    end else if (cdb_flush) begin
      q.delete();
      {e_rs, e_reg, e_lsb, e_br, e_bj, e_jalr} = '0;
    end else if (rdy) begin
      if (DEPTH - q.size() >= NCH) begin
        for (int l = 0; l < NCH; l++) begin
          if (commit_valid[l]) begin
            e.value   = commit_value[l*XLEN +: XLEN];
            e.next_pc = commit_next_pc[l*XLEN +: XLEN];
            e.rename  = commit_rename[l*TAG_W +: TAG_W];
            e.dest    = commit_dest[l*5 +: 5];
            e.kind    = commit_kind[l*2 +: 2];
            q.push_back(e);
          end
        end
      end
      {e_rs, e_reg, e_lsb, e_br, e_bj, e_jalr} = '0;
      if (!bcast_stall) begin
        for (int j = 0; j < NCH; j++) begin
          if (q.size() > 0) decode(j, q.pop_front());
        end
      end
    end
  endtask

  task automatic check_outputs();
    for (int j = 0; j < NCH; j++) begin
      chk("rs_update_flag", j, rs_update_flag[j], e_rs[j]);
      chk("register_update_flag", j, register_update_flag[j], e_reg[j]);
      chk("lsb_update_flag", j, lsb_update_flag[j], e_lsb[j]);
      chk("branch_commit", j, branch_commit[j], e_br[j]);
      chk("branch_jump", j, branch_jump[j], e_bj[j]);
      chk("jalr_commit", j, jalr_commit[j], e_jalr[j]);
      if (e_rs[j] || was_rst) begin
        chk("rs_commit_rename", j, rs_commit_rename[j*TAG_W +: TAG_W], e_rs_tag[j]);
        chk("rs_value", j, rs_value[j*XLEN +: XLEN], e_rs_val[j]);
      end
      if (e_reg[j] || was_rst) begin
        chk("register_commit_dest", j, register_commit_dest[j*5 +: 5], e_reg_dest[j]);
        chk("register_value", j, register_value[j*XLEN +: XLEN], e_reg_val[j]);
        chk("rename_sent_to_register", j, rename_sent_to_register[j*TAG_W +: TAG_W], e_reg_tag[j]);
      end
      if (e_lsb[j] || was_rst)
        chk("lsb_commit_rename", j, lsb_commit_rename[j*TAG_W +: TAG_W], e_lsb_tag[j]);
      if (e_jalr[j] || was_rst)
        chk("jalr_addr", j, jalr_addr[j*XLEN +: XLEN], e_jaddr[j]);
    end
  endtask

  task automatic cycle();
    #1;
    if (!rst) chk("commit_ready", 0, commit_ready, rdy && !cdb_flush && (DEPTH - q.size() >= NCH));
    model_step();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; cdb_flush = 1'b0; bcast_stall = 1'b0;
    commit_valid = '1;
    set_lane(0, 2'd0, 5'd9, 4'd1, 32'hAA, 32'h0);
    set_lane(1, 2'd3, 5'd8, 4'd2, 32'hBB, 32'h4);
    cycle(); cycle();
    idle(); cycle(); cycle();

    commit_valid = 2'b11;
    set_lane(0, 2'd0, 5'd5, 4'd3, 32'h11, 32'h0);
    set_lane(1, 2'd1, 5'd0, 4'd4, 32'h22, 32'h0);
    cycle();
    idle(); cycle();

    commit_valid = 2'b01;
    set_lane(0, 2'd3, 5'd0, 4'd5, 32'h100, 32'h24);
    cycle();
    set_lane(0, 2'd3, 5'd1, 4'd6, 32'h100, 32'h24);
    cycle();

    commit_valid = 2'b10;
    set_lane(1, 2'd2, 5'd7, 4'd7, 32'h1, 32'h0);
    cycle();
    idle(); cycle();

    bcast_stall = 1'b1;
    for (int c = 0; c < 4; c++) begin
      commit_valid = '1;
      set_lane(0, 2'd0, 5'(2*c + 1), 4'(2*c), 32'(100 + 2*c), 32'h0);
      set_lane(1, 2'd0, 5'(2*c + 2), 4'(2*c + 1), 32'(101 + 2*c), 32'h0);
      cycle();
    end
    set_lane(0, 2'd0, 5'd3, 4'hF, 32'hDEAD, 32'h0);
    set_lane(1, 2'd0, 5'd3, 4'hE, 32'hBEEF, 32'h0);
    cycle();
    idle();
    for (int c = 0; c < 6; c++) cycle();

    for (int pass = 0; pass < 2; pass++) begin
      idle();
      bcast_stall = 1'b1;
      for (int c = 0; c < 3; c++) begin
        commit_valid = '1;
        rand_lane(0); rand_lane(1);
        cycle();
      end
      cdb_flush = 1'b1;
      rdy = (pass == 0);
      rand_lane(0); rand_lane(1);
      cycle();
      idle();
      for (int c = 0; c < 4; c++) cycle();
    end

    for (int c = 0; c < 500; c++) begin
      rst          = ($urandom_range(0, 99) == 0);
      rdy          = ($urandom_range(0, 9) != 0);
      cdb_flush    = ($urandom_range(0, 39) == 0);
      bcast_stall  = (c < 250) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 0);
      commit_valid = NCH'($urandom);
      for (int l = 0; l < NCH; l++) rand_lane(l);
      cycle();
    end
    idle();
    for (int c = 0; c < 6; c++) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/cdb_multi.md
Name: cdb_multi

Overview:
- Multi-lane, registered common data bus for the Tomasulo core. Accepts up to NCH in-order commits per cycle from the ROB and buffers them in a DEPTH-entry FIFO.
- Each cycle it broadcasts up to NCH entries to the RS, register file, LSB, predictor and IF.
- Over a single-lane combinational bus it adds: multi-lane commit, backpressure, broadcast stall, x0 write suppression and per-lane flush-safe clearing.

Parameters:
NCH, 2, commit/broadcast lanes per cycle (1..4)
TAG_W, 4, ROB rename tag width
DEPTH, 8, FIFO entries; power of two, >= 2*NCH
XLEN, 32, data width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
rdy  in  1  global enable; low freezes all state
commit_valid  in  NCH  per-lane commit present; lane 0 is oldest
commit_value  in  NCH*XLEN  result; branch taken in bit 0; jalr target
commit_rename  in  NCH*TAG_W  ROB tag
commit_dest  in  NCH*5  architectural rd
commit_kind  in  NCH*2  0=alu/load, 1=store, 2=branch, 3=jalr
commit_next_pc  in  NCH*XLEN  pc+4 for jalr link
commit_ready  out  1  FIFO can take NCH entries this cycle
cdb_flush  in  1  mispredict flush
bcast_stall  in  1  sinks cannot accept broadcast this cycle
rs_update_flag  out  NCH  per-lane RS wakeup
rs_commit_rename  out  NCH*TAG_W  RS tag
rs_value  out  NCH*XLEN  RS value
register_update_flag  out  NCH  regfile write
register_commit_dest  out  NCH*5  regfile rd
register_value  out  NCH*XLEN  regfile data
rename_sent_to_register  out  NCH*TAG_W  tag for rename-table clear
lsb_update_flag  out  NCH  LSB commit notice
lsb_commit_rename  out  NCH*TAG_W  LSB tag
branch_commit  out  NCH  branch retired
branch_jump  out  NCH  branch outcome
jalr_commit  out  NCH  jalr retired
jalr_addr  out  NCH*XLEN  jalr target

Behaviour:
- Reset, when rst is high at a clk edge:
  - FIFO is emptied: head = tail = count = 0.
  - All flag outputs are 0. All data and tag outputs are 0.
  - rst overrides rdy and cdb_flush.
- Priority: rst > cdb_flush > !rdy > normal operation.
- rdy low:
  - No push, no pop; outputs hold their values.
  - commit_ready = 0.
- commit_ready = rdy && !cdb_flush && (DEPTH - count >= NCH). It is computed from registered count only.
- Push:
  - Happens when commit_ready is high. Every lane with commit_valid=1 is written at consecutive tail slots, in lane order; invalid lanes are compacted out.
  - tail advances by popcount(commit_valid), wrapping mod DEPTH.
  - Valid lanes presented while commit_ready=0 are ignored. The ROB must hold them.
- Pop, when rdy=1, !bcast_stall and !cdb_flush:
  - Pops min(NCH, count + pushed) entries, oldest first.
  - Same-cycle bypass: incoming entries are eligible behind the stored ones.
  - Popped entry i drives output lane i at the next edge. Lanes with no entry drive all flags 0.
  - Latency: push in cycle t is visible on outputs in cycle t+1 when the FIFO is empty and there is no stall.
- Per-lane decode of a popped entry (flags registered):
  - kind 0:
    - rs_update=1 with rename/value.
    - register_update=1 with dest/value/rename. register_update is forced to 0 if dest==0.
    - lsb_update=1 with rename.
  - kind 1: lsb_update=1 only.
  - kind 2: branch_commit=1, branch_jump=value[0]; all other flags 0.
  - kind 3:
    - jalr_commit=1, jalr_addr=value.
    - register_update=1 with value=next_pc and rename. register_update is 0 if dest==0.
    - rs and lsb flags are 0.
- bcast_stall=1 with rdy=1:
  - No pop. All output flags go 0 at the next edge; data outputs hold.
  - Push continues while commit_ready allows.
- cdb_flush=1 at an edge:
  - FIFO is cleared (count=0, head=tail).
  - Inputs in that cycle are discarded.
  - All output flags go 0 at that edge.
  - Honoured even when rdy=0.
- Invariant: count never exceeds DEPTH. Simultaneous push and pop updates count by pushed - popped.
- Broadcast order equals commit order across lanes and cycles.

Test Plan:
- Reset: hold rst 2 cycles while commit_valid=11 -> after release, all flags 0, commit_ready=1, nothing broadcast.
- Dual commit with bypass: cycle t, lane0 kind0 dest=5 value=0x11 tag=3, lane1 kind1 tag=4 -> t+1:
  - rs_update=01, register_update=01 dest=5 value=0x11, lsb_update=11 with tags 3,4.
  - t+2: all flags 0.
- x0 and jalr: kind3 dest=0 value=0x100 next_pc=0x24 -> jalr_commit lane0=1, jalr_addr=0x100, register_update=0. Repeat with dest=1 -> register_update=1, register_value=0x24.
- Compaction: commit_valid=10, lane1 kind2 value=1 -> output lane 0 has branch_commit=1, branch_jump=1; lane 1 flags 0.
- Stall and backpressure (NCH=2, DEPTH=8): bcast_stall=1, push 2 entries/cycle for 4 cycles -> commit_ready falls to 0 after count=8. Release stall -> 2 entries/cycle broadcast in original order, tags 0..7.
- Flush: fill count=6, assert cdb_flush with valid inputs -> next cycle all flags 0, count=0, commit_ready=1; no stale entry ever broadcast. Repeat with rdy=0 during the flush -> same result.
